clkdiv_ctrl: RTL
================

CLKDIV_CTRL -- requirements
Module: clkdiv_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of the half-period count.
REQ-002 SHALL have parameter DIV_RST, default 1: half-period loaded at reset (divide-by-2).
REQ-003 SHALL have port clk, input, 1: sole clock; all logic on posedge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port enable, input, 1: run request for the divided clock.
REQ-006 SHALL have port req_valid, input, 1: new half-period offered.
REQ-007 SHALL have port req_div, input, CNT_W: requested half-period H, in input cycles.
REQ-008 SHALL have port req_ready, output, 1: request accepted when req_valid && req_ready at posedge.
REQ-009 SHALL have port clk_out, output, 1: registered divided clock, period 2*H.
REQ-010 SHALL have port clk_en, output, 1: one-cycle pulse in the first cycle clk_out is high.
REQ-011 SHALL have port div_active, output, CNT_W: half-period currently in effect.
REQ-012 SHALL have port busy, output, 1: high in RUN or PEND.

Function
REQ-013 SHALL implement states IDLE, RUN, PEND.
REQ-014 In IDLE: clk_out=0, counter=0, req_ready=1; an accepted request updates div_active on the next edge.
REQ-015 IDLE with enable=1 at an edge -> RUN; clk_out=1 and clk_en=1 after that edge; counter=0.
REQ-016 In RUN/PEND: counter increments each cycle; at counter==div_active-1, counter clears and clk_out toggles; with H=1, clk_out toggles every cycle.
REQ-017 RUN: req_ready=1; an accepted request latches into a pending register; state becomes PEND.
REQ-018 PEND: req_ready=0; the pending H is loaded into div_active on the edge where clk_out goes 1->0; state returns to RUN; the low phase uses the new H.
REQ-019 enable=0 in RUN/PEND: if clk_out=0, go to IDLE on the next edge; if clk_out=1, complete the high phase, then go to IDLE on its 1->0 toggle. Partial high pulses are not permitted.
REQ-020 A pending request coinciding with stop SHALL be applied on the same 1->0 edge.
REQ-021 req_div=0 SHALL be handled per REQ-026/027 and SHALL never reach div_active.
REQ-022 Counter wrap: div_active = 2^CNT_W-1 is legal; the counter never exceeds div_active-1.

Reset
REQ-023 rst SHALL force IDLE, clk_out=0, clk_en=0, counter=0, div_active=DIV_RST, pending cleared, busy=0, req_ready=1 (err=0 if present).
REQ-024 rst mid-period SHALL abort immediately; the aborted output is not required to be glitch-free.
REQ-025 rst SHALL take priority over enable and req_valid in the same cycle.

Configuration
REQ-026 With CLKDIV_CTRL_ERR_EN defined: output err, 1 bit, pulses for one cycle after acceptance of req_div=0; the request is consumed, with no state change.
REQ-027 Without CLKDIV_CTRL_ERR_EN: no err port; req_div=0 is saturated to 1.

Structure
REQ-028 Package clkdiv_pkg SHALL hold the state enum, default CNT_W, and DIV_RST.
REQ-029 Counter and toggle logic SHALL sit in sub-module clkdiv_core (load, run, div, clk_out, wrap); the FSM, handshake and pending register stay in clkdiv_ctrl.

Verification
REQ-030 Reset, then enable=1: clk_out toggles every clk (H=1); 20 cycles with 0 mismatches; clk_en every 2nd cycle.
REQ-031 IDLE, request H=3, then enable: clk_out is 3 high / 3 low; div_active=3.
REQ-032 RUN with H=2, request H=5 mid high phase: req_ready=0 until the 1->0 edge; the low phase is 5 cycles; there is no short pulse.
REQ-033 Deassert enable in the first high cycle with H=4: clk_out stays high 4 cycles, then 0; busy falls on the same edge.
REQ-034 req_div=0: err pulses once (ERR_EN); otherwise div_active=1.
REQ-035 rst asserted mid-period with H=6: the next cycle has clk_out=0, div_active=1, and state IDLE.

Source files
------------

// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg: shared types and defaults for the clock divider controller.
// Optional feature macro used across the slice: CLKDIV_CTRL_ERR_EN.
package clkdiv_pkg;

    // Controller states: stopped, running, running with a queued half-period.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } state_t;

    // Default width of the half-period counter.
    localparam int CNT_W_DEFAULT   = 8;

    // Half-period loaded at reset: 1 gives divide-by-2.
    localparam int DIV_RST_DEFAULT = 1;

endpackage

// File: rtl/clkdiv_if.sv
// clkdiv_if: half-period request handshake (valid/ready with payload).
interface clkdiv_if
    import clkdiv_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) ();

    logic             req_valid;
    logic [CNT_W-1:0] req_div;
    logic             req_ready;

    modport master (output req_valid, output req_div, input req_ready);
    modport slave  (input req_valid, input req_div, output req_ready);

endinterface

// File: rtl/clkdiv_core.sv
// clkdiv_core: half-period counter and divided-clock toggle.
// load starts a high phase, run advances the counter, and with neither
// asserted the output is forced low and the counter is cleared.
module clkdiv_core #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             run,
    input  logic [CNT_W-1:0] div,
    output logic             clk_out,
    output logic             clk_en,
    output logic             wrap
);

    logic [CNT_W-1:0] cnt;

    // Last cycle of the current phase; div is never zero so div-1 cannot underflow.
    assign wrap = run && (cnt == (div - CNT_W'(1)));

    // Counter, output toggle and the first-high-cycle strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            clk_out <= 1'b0;
            clk_en  <= 1'b0;
        end else if (load) begin
            cnt     <= '0;
            clk_out <= 1'b1;
            clk_en  <= 1'b1;
        end else if (run) begin
            clk_en <= wrap && !clk_out;
            if (wrap) begin
                cnt     <= '0;
                clk_out <= ~clk_out;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end else begin
            cnt     <= '0;
            clk_out <= 1'b0;
            clk_en  <= 1'b0;
        end
    end

endmodule

// File: rtl/clkdiv_ctrl.sv
// clkdiv_ctrl: programmable clock divider with glitch-free retuning.
// New half-periods are queued while running and take effect on a 1->0 edge,
// and stopping always completes a started high phase.
// Optional feature macro: CLKDIV_CTRL_ERR_EN adds an err pulse for a zero
// half-period request; without it a zero request is saturated to 1.
module clkdiv_ctrl
    import clkdiv_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEFAULT,
    parameter int DIV_RST = DIV_RST_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    clkdiv_if.slave          req,
    output logic             clk_out,
    output logic             clk_en,
    output logic [CNT_W-1:0] div_active,
    output logic             busy
`ifdef CLKDIV_CTRL_ERR_EN
    ,
    output logic             err
`endif
);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] pend_div, pend_nxt, div_nxt;
    logic [CNT_W-1:0] req_h;
    logic             req_ok, req_zero, acc, load, run, wrap, fall, stop;

    assign req.req_ready = (state != ST_PEND);
    assign busy          = (state != ST_IDLE);
    assign acc           = req.req_valid && req.req_ready;
    assign req_zero      = (req.req_div == '0);
    assign fall          = wrap && clk_out;
    assign stop          = !enable && (!clk_out || fall);

`ifdef CLKDIV_CTRL_ERR_EN
    // A zero request is consumed but otherwise ignored.
    assign req_ok = acc && !req_zero;
    assign req_h  = req.req_div;

    // One-cycle error pulse after a zero request is accepted.
    always_ff @(posedge clk) begin
        if (rst) err <= 1'b0;
        else     err <= acc && req_zero;
    end
`else
    assign req_ok = acc;
    assign req_h  = req_zero ? CNT_W'(1) : req.req_div;
`endif

    // State, active half-period and pending half-period registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            div_active <= CNT_W'(DIV_RST);
            pend_div   <= CNT_W'(DIV_RST);
        end else begin
            state      <= state_nxt;
            div_active <= div_nxt;
            pend_div   <= pend_nxt;
        end
    end

    // Next-state, half-period updates and core controls.
    always_comb begin
        state_nxt = state;
        div_nxt   = div_active;
        pend_nxt  = pend_div;
        load      = 1'b0;
        run       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_ok) div_nxt = req_h;
                if (enable) begin
                    load      = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                run = clk_out || enable;
                if (stop) begin
                    state_nxt = ST_IDLE;
                    if (req_ok) div_nxt = req_h;
                end else if (req_ok) begin
                    pend_nxt  = req_h;
                    state_nxt = ST_PEND;
                end
            end
            ST_PEND: begin
                run = clk_out || enable;
                if (stop) begin
                    div_nxt   = pend_div;
                    state_nxt = ST_IDLE;
                end else if (fall) begin
                    div_nxt   = pend_div;
                    state_nxt = ST_RUN;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    clkdiv_core #(.CNT_W(CNT_W)) u_core (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .run     (run),
        .div     (div_active),
        .clk_out (clk_out),
        .clk_en  (clk_en),
        .wrap    (wrap)
    );

endmodule
